// File: rtl/noc_step_sequencer_pkg.sv
// Shared definitions for the NoC step sequencer: broadcast op codes, default
// widths, sequencer state encoding and a small op-selection helper.
package noc_step_sequencer_pkg;

    localparam int OP_SIZE       = 3;
    localparam int IN_CYCLE_SIZE = 16;
    localparam int DATA_BIT_SIZE = 32;

    typedef enum logic [OP_SIZE-1:0] {
        OP_NOP          = 3'd0,
        OP_INIT         = 3'd1,
        OP_LOAD_RT      = 3'd2,
        OP_LOAD_STAGING = 3'd3,
        OP_PHASE0       = 3'd4,
        OP_PHASE1       = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_STAGE,
        ST_PH0,
        ST_PH1,
        ST_CHECK,
        ST_FINISH
    } seq_state_e;

    // The first accepted config beat is the Init word; all later ones are routing entries.
    function automatic op_e cfg_beat_op(input logic first_beat);
        return first_beat ? OP_INIT : OP_LOAD_RT;
    endfunction

endpackage

// File: rtl/noc_step_sequencer_if.sv
// Config stream interface feeding the NoC step sequencer (valid/ready beats
// with a last marker). The host is the master, the sequencer the slave.
interface noc_step_sequencer_if #(
    parameter int DATA_W = 32
) ();

    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_last;

    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_last,
        output cfg_ready
    );

endinterface

// File: rtl/noc_quiesce_detect.sv
// Quiescence detector: AND-reduces the router done bits and captures them in
// the cycle after each phase strobe, when the broadcast phase op has reached
// the routers and their done bits (updated on negedge) have settled.
import noc_step_sequencer_pkg::*;

module noc_quiesce_detect #(
    parameter int NUM_ROUTERS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample0,
    input  logic                   sample1,
    input  logic [NUM_ROUTERS-1:0] router_done,
    output logic                   quiescent
);

    logic all_done;
    logic pend0_q;
    logic pend1_q;
    logic d0_q;
    logic d1_q;

    assign all_done = &router_done;

    // Delay each strobe by one cycle, then latch the reduced done bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            d0_q    <= 1'b0;
            d1_q    <= 1'b0;
        end else begin
            pend0_q <= sample0;
            pend1_q <= sample1;
            if (pend0_q) d0_q <= all_done;
            if (pend1_q) d1_q <= all_done;
        end
    end

    // d1 is consumed in the same cycle it is captured, so bypass the live value then.
    always_comb begin
        quiescent = d0_q & (pend1_q ? all_done : d1_q);
    end

endmodule

// File: rtl/noc_step_sequencer.sv
// NoC step sequencer: streams the configuration (Init then LoadRt entries)
// and then repeats LoadStaging -> Phase0 -> Phase1 per simulated cycle until
// every router is done, broadcasting registered op/data/in_cycle.
// Optional feature macro: NOC_SEQ_TIMEOUT_EN (timeout against max_cycles).
import noc_step_sequencer_pkg::*;

module noc_step_sequencer #(
    parameter int NUM_ROUTERS = 16,
    parameter int CYCLE_W     = IN_CYCLE_SIZE,
    parameter int DATA_W      = DATA_BIT_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    noc_step_sequencer_if.slave    cfg,
    input  logic                   hold,
    input  logic [CYCLE_W-1:0]     max_cycles,
    input  logic [NUM_ROUTERS-1:0] router_done,
    output logic [OP_SIZE-1:0]     op,
    output logic [DATA_W-1:0]      data,
    output logic [CYCLE_W-1:0]     in_cycle,
    output logic                   busy,
    output logic                   finished,
    output logic                   timed_out
);

    seq_state_e        state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CYCLE_W-1:0] cyc_q, cyc_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;
    logic              to_q, to_d;
    logic              first_q, first_d;
    logic              rdy_q;
    logic              quiescent;

`ifndef NOC_SEQ_TIMEOUT_EN
    logic unused_max_cycles;
    assign unused_max_cycles = ^max_cycles;
`endif

    noc_quiesce_detect #(
        .NUM_ROUTERS(NUM_ROUTERS)
    ) u_quiesce (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample0    (state_q == ST_PH0),
        .sample1    (state_q == ST_PH1),
        .router_done(router_done),
        .quiescent  (quiescent)
    );

    // State and registered broadcast outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            to_q    <= 1'b0;
            first_q <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            to_q    <= to_d;
            first_q <= first_d;
            rdy_q   <= (state_d == ST_CFG);
        end
    end

    // Next-state and next-output logic. The op chosen in a state reaches the
    // routers one cycle later, which is why done bits are sampled a cycle late.
    always_comb begin
        state_d = state_q;
        op_d    = OP_NOP;
        data_d  = data_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        to_d    = to_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CFG;
                    busy_d  = 1'b1;
                    to_d    = 1'b0;
                    cyc_d   = '0;
                    first_d = 1'b1;
                end
            end
            ST_CFG: begin
                if (cfg.cfg_valid && rdy_q) begin
                    op_d    = cfg_beat_op(first_q);
                    data_d  = cfg.cfg_data;
                    first_d = 1'b0;
                    if (cfg.cfg_last) state_d = ST_STAGE;
                end
            end
            ST_STAGE: begin
                op_d    = OP_LOAD_STAGING;
                state_d = ST_PH0;
            end
            ST_PH0: begin
                op_d    = OP_PHASE0;
                state_d = ST_PH1;
            end
            ST_PH1: begin
                op_d    = OP_PHASE1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (quiescent) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                end
`ifdef NOC_SEQ_TIMEOUT_EN
                else if ((max_cycles != '0) && (cyc_q == max_cycles)) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                    to_d    = 1'b1;
                end
`endif
                else if (hold) begin
                    state_d = ST_CHECK;
                end else begin
                    cyc_d   = cyc_q + 1'b1;
                    state_d = ST_STAGE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cfg.cfg_ready = rdy_q;
    assign op            = op_q;
    assign data          = data_q;
    assign in_cycle      = cyc_q;
    assign busy          = busy_q;
    assign finished      = fin_q;
`ifdef NOC_SEQ_TIMEOUT_EN
    assign timed_out     = to_q;
`else
    logic unused_to;
    assign unused_to     = to_q;
    assign timed_out     = 1'b0;
`endif

endmodule
